// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - parametrised up/down counter with modulus, step, load and wrap/saturate limits
// Cascade digits by driving the next stage's choose with {unf, 1'b0, ovf} and step = 1.
module updown_counter_n #(
  parameter int WIDTH     = 3,
  parameter int MAX       = 2**WIDTH-1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       choose,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             unf,
  output logic             at_max,
  output logic             at_min
);

  typedef enum logic [2:0] {
    CMD_UP   = 3'b001,
    CMD_LOAD = 3'b010,
    CMD_DOWN = 3'b100
  } cmd_e;

  // One extra bit so MAX+1 (the modulus) is representable even when MAX = 2**WIDTH-1.
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MAX + 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] l_eff;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   up_wrap;
  logic [WIDTH:0]   dn_wrap;

  always_comb begin
    s_eff   = (step > MAX_W) ? MAX_W : step;
    l_eff   = (load_val > MAX_W) ? MAX_W : load_val;
    up_sum  = {1'b0, out_q} + {1'b0, s_eff};
    up_wrap = up_sum - MOD_X;
    // Only used when out_q < s_eff, so the result always lands in 0..MAX.
    dn_wrap = {1'b0, out_q} + MOD_X - {1'b0, s_eff};

    out_d = out_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;

    case (choose)
      CMD_UP: begin
        if (up_sum <= MAX_X) begin
          out_d = up_sum[WIDTH-1:0];
        end else begin
          ovf_d = 1'b1;
          out_d = sat_mode ? MAX_W : up_wrap[WIDTH-1:0];
        end
      end
      CMD_DOWN: begin
        if (out_q >= s_eff) begin
          out_d = out_q - s_eff;
        end else begin
          unf_d = 1'b1;
          out_d = sat_mode ? '0 : dn_wrap[WIDTH-1:0];
        end
      end
      CMD_LOAD: out_d = l_eff;
      default:  out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= RST_W;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign out    = out_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign at_max = (out_q == MAX_W);
  assign at_min = (out_q == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// tb/tb_updown_counter_n.sv - directed self-checking bench for updown_counter_n
// Instance a: WIDTH=4, MAX=9, RESET_VAL=5; instance b: default parameters.
module tb_updown_counter_n;

  localparam logic [2:0] UP   = 3'b001;
  localparam logic [2:0] LOAD = 3'b010;
  localparam logic [2:0] DOWN = 3'b100;
  localparam logic [2:0] HOLD = 3'b000;

  logic       clk = 1'b0;
  logic       rst;

  logic [2:0] a_choose;
  logic [3:0] a_step, a_load;
  logic       a_sat;
  logic [3:0] out_a;
  logic       ovf_a, unf_a, at_max_a, at_min_a;

  logic [2:0] b_choose;
  logic [2:0] b_step, b_load;
  logic       b_sat;
  logic [2:0] out_b;
  logic       ovf_b, unf_b, at_max_b, at_min_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(4), .MAX(9), .RESET_VAL(5)) dut_a (
    .clk(clk), .rst(rst), .choose(a_choose), .step(a_step), .load_val(a_load),
    .sat_mode(a_sat), .out(out_a), .ovf(ovf_a), .unf(unf_a),
    .at_max(at_max_a), .at_min(at_min_a)
  );

  updown_counter_n dut_b (
    .clk(clk), .rst(rst), .choose(b_choose), .step(b_step), .load_val(b_load),
    .sat_mode(b_sat), .out(out_b), .ovf(ovf_b), .unf(unf_b),
    .at_max(at_max_b), .at_min(at_min_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] c, input logic [3:0] st,
                         input logic [3:0] lv, input logic sm);
    a_choose = c; a_step = st; a_load = lv; a_sat = sm;
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input logic [2:0] c, input logic [2:0] st, input logic [2:0] lv);
    b_choose = c; b_step = st; b_load = lv; b_sat = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic expect_a(input string tag, input int o, input int ov, input int un);
    check({tag, ".out"}, out_a, o);
    check({tag, ".ovf"}, ovf_a, ov);
    check({tag, ".unf"}, unf_a, un);
    check({tag, ".at_max"}, at_max_a, (o == 9) ? 1 : 0);
    check({tag, ".at_min"}, at_min_a, (o == 0) ? 1 : 0);
  endtask

  task automatic expect_b(input string tag, input int o, input int ov, input int un);
    check({tag, ".out"}, out_b, o);
    check({tag, ".ovf"}, ovf_b, ov);
    check({tag, ".unf"}, unf_b, un);
    check({tag, ".at_max"}, at_max_b, (o == 7) ? 1 : 0);
    check({tag, ".at_min"}, at_min_b, (o == 0) ? 1 : 0);
  endtask

  initial begin
    rst = 1'b1;
    a_choose = HOLD; a_step = '0; a_load = '0; a_sat = 1'b0;
    b_choose = HOLD; b_step = '0; b_load = '0; b_sat = 1'b0;
    #12;
    expect_a("reset_a", 5, 0, 0);
    expect_b("reset_b", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Count 5 -> 6 -> 7, then reset asynchronously mid-cycle.
    drive_a(UP, 4'd1, 4'd0, 1'b0);
    expect_a("first_up", 6, 0, 0);
    drive_a(UP, 4'd1, 4'd0, 1'b0);
    expect_a("second_up", 7, 0, 0);
    a_choose = LOAD; a_load = 4'd0;
    #2 rst = 1'b1;
    #1 expect_a("async_rst", 5, 0, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    expect_a("load0", 0, 0, 0);

    for (int i = 1; i <= 10; i++) begin
      drive_a(UP, 4'd1, 4'd0, 1'b0);
      expect_a($sformatf("wrap_up%0d", i), i % 10, (i == 10) ? 1 : 0, 0);
    end

    drive_a(LOAD, 4'd0, 4'd8, 1'b0);
    drive_a(UP, 4'd3, 4'd0, 1'b0);
    expect_a("up3_from8", 1, 1, 0);
    drive_a(UP, 4'd3, 4'd0, 1'b0);
    expect_a("ovf_clears", 4, 0, 0);

    drive_a(LOAD, 4'd0, 4'd1, 1'b0);
    drive_a(DOWN, 4'd4, 4'd0, 1'b0);
    expect_a("down4_from1", 7, 0, 1);
    drive_a(DOWN, 4'd7, 4'd0, 1'b0);
    expect_a("down7_from7", 0, 0, 0);
    drive_a(DOWN, 4'd15, 4'd0, 1'b0);
    expect_a("down_clamped_from0", 1, 0, 1);

    drive_a(LOAD, 4'd0, 4'd8, 1'b1);
    drive_a(UP, 4'd3, 4'd0, 1'b1);
    expect_a("sat_up3_from8", 9, 1, 0);
    drive_a(UP, 4'd3, 4'd0, 1'b1);
    expect_a("sat_up_again", 9, 1, 0);
    drive_a(LOAD, 4'd0, 4'd2, 1'b1);
    drive_a(DOWN, 4'd5, 4'd0, 1'b1);
    expect_a("sat_down5_from2", 0, 0, 1);
    drive_a(DOWN, 4'd1, 4'd0, 1'b1);
    expect_a("sat_down_again", 0, 0, 1);

    drive_a(LOAD, 4'd0, 4'd6, 1'b0);
    expect_a("load6", 6, 0, 0);
    drive_a(LOAD, 4'd0, 4'd14, 1'b0);
    expect_a("load14_clamp", 9, 0, 0);
    drive_a(LOAD, 4'd0, 4'd0, 1'b0);
    drive_a(UP, 4'd15, 4'd0, 1'b0);
    expect_a("up15_clamp", 9, 0, 0);

    drive_a(LOAD, 4'd0, 4'd4, 1'b0);
    drive_a(3'b011, 4'd2, 4'd7, 1'b0);
    expect_a("hold011", 4, 0, 0);
    drive_a(3'b111, 4'd2, 4'd7, 1'b0);
    expect_a("hold111", 4, 0, 0);
    drive_a(HOLD, 4'd2, 4'd7, 1'b0);
    expect_a("hold000", 4, 0, 0);
    drive_a(UP, 4'd0, 4'd0, 1'b0);
    expect_a("up_step0", 4, 0, 0);
    drive_a(DOWN, 4'd0, 4'd0, 1'b0);
    expect_a("down_step0", 4, 0, 0);
    a_choose = HOLD;

    drive_b(LOAD, 3'd0, 3'd7);
    expect_b("b_load7", 7, 0, 0);
    drive_b(UP, 3'd1, 3'd0);
    expect_b("b_up_from7", 0, 1, 0);
    drive_b(DOWN, 3'd1, 3'd0);
    expect_b("b_down_from0", 7, 0, 1);
    drive_b(UP, 3'd7, 3'd0);
    expect_b("b_up7_from7", 6, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
